// File: rtl/nabeatsu_pkg.sv
// Shared types and constants for the nabeatsu judge counter.
package nabeatsu_pkg;

  localparam logic [1:0] MODE_OR  = 2'b00;
  localparam logic [1:0] MODE_DIV = 2'b01;
  localparam logic [1:0] MODE_DIG = 2'b10;
  localparam logic [1:0] MODE_AND = 2'b11;

  typedef logic [3:0] bcd_digit_t;

  // Decode up to five packed BCD digits, digit 0 in bits [3:0].
  function automatic int unsigned bcd_to_bin(input logic [19:0] bcd, input int unsigned n);
    int unsigned v;
    v = 0;
    for (int i = int'(n) - 1; i >= 0; i--) begin
      v = v * 10 + int'(bcd[i*4 +: 4]);
    end
    return v;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decimal digit of the counter: ripple increment, wrap load and digit match.
module bcd_digit_cell
  import nabeatsu_pkg::*;
#(
  parameter int unsigned MATCH_DIGIT = 3,
  parameter bit          IS_LSD      = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  input  logic       load_one,
  input  logic       carry_in,
  output bcd_digit_t digit,
  output logic       carry_out,
  output logic       is_match,
  output logic       is_nonzero
);

  bcd_digit_t digit_q;

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      digit_q <= '0;
    end else if (load_one) begin
      digit_q <= IS_LSD ? 4'd1 : 4'd0;
    end else if (carry_in) begin
      digit_q <= (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end
  end

  assign digit      = digit_q;
  assign carry_out  = carry_in && (digit_q == 4'd9);
  assign is_match   = (digit_q == 4'(MATCH_DIGIT));
  assign is_nonzero = (digit_q != 4'd0);

endmodule

// File: rtl/nabeatsu_counter.sv
// Binary/BCD counter with a running remainder that flags multiples of DIVISOR
// and counts containing MATCH_DIGIT, combined per MODE.
module nabeatsu_counter
  import nabeatsu_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 3,
  parameter int unsigned MAX_COUNT   = 999,
  parameter int unsigned DIVISOR     = 3,
  parameter int unsigned MATCH_DIGIT = 3,
  localparam int unsigned BIN_W      = $clog2(MAX_COUNT + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic                    CLR,
  input  logic [1:0]              MODE,
  output logic [BIN_W-1:0]        COUNT,
  output logic [4*NUM_DIGITS-1:0] BCD,
  output logic                    DIV_HIT,
  output logic                    DIGIT_HIT,
  output logic                    AHO,
  output logic                    WRAP
);

  localparam int unsigned REM_W = $clog2(DIVISOR);

  if (MAX_COUNT > 10 ** NUM_DIGITS - 1) begin : g_bad_max_count
    $error("MAX_COUNT does not fit in NUM_DIGITS decimal digits");
  end

  logic [BIN_W-1:0]      cnt_q;
  logic [REM_W-1:0]      rem_q;
  logic                  wrap_q;
  logic                  at_max;
  logic                  step;
  logic [NUM_DIGITS:0]   carry;
  logic [NUM_DIGITS-1:0] is_match;
  logic [NUM_DIGITS-1:0] is_nonzero;
  logic [NUM_DIGITS-1:0] significant;
  logic                  unused_top_carry;

  assign at_max = (cnt_q == BIN_W'(MAX_COUNT));
  assign step   = EN && !CLR && !RST;

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      wrap_q <= 1'b0;
    end else if (EN) begin
      if (at_max) begin
        // Wrap lands on 1, so the remainder restarts at 1 mod DIVISOR (DIVISOR >= 2).
        cnt_q  <= BIN_W'(1);
        rem_q  <= REM_W'(1);
        wrap_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + BIN_W'(1);
        rem_q  <= (rem_q == REM_W'(DIVISOR - 1)) ? '0 : rem_q + REM_W'(1);
        wrap_q <= 1'b0;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign carry[0] = step && !at_max;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_cell #(
      .MATCH_DIGIT (MATCH_DIGIT),
      .IS_LSD      (i == 0)
    ) u_cell (
      .CLK        (CLK),
      .RST        (RST),
      .CLR        (CLR),
      .load_one   (step && at_max),
      .carry_in   (carry[i]),
      .digit      (BCD[4*i +: 4]),
      .carry_out  (carry[i+1]),
      .is_match   (is_match[i]),
      .is_nonzero (is_nonzero[i])
    );
  end

  assign unused_top_carry = carry[NUM_DIGITS];

  // A digit counts only at or below the highest nonzero digit.
  always_comb begin
    significant = '0;
    significant[NUM_DIGITS-1] = is_nonzero[NUM_DIGITS-1];
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      significant[i] = significant[i+1] || is_nonzero[i];
    end
  end

  assign DIV_HIT   = (cnt_q != '0) && (rem_q == '0);
  assign DIGIT_HIT = |(is_match & significant);

  always_comb begin
    AHO = 1'b0;
    case (MODE)
      MODE_OR:  AHO = DIV_HIT || DIGIT_HIT;
      MODE_DIV: AHO = DIV_HIT;
      MODE_DIG: AHO = DIGIT_HIT;
      MODE_AND: AHO = DIV_HIT && DIGIT_HIT;
      default:  AHO = 1'b0;
    endcase
    AHO = AHO && (cnt_q != '0);
  end

  assign COUNT = cnt_q;
  assign WRAP  = wrap_q;

endmodule

// File: tb/tb_nabeatsu_counter.sv
// Scoreboard bench: two counter instances (defaults, and DIVISOR=7/MATCH_DIGIT=0) share stimulus.
module tb_nabeatsu_counter;
  import nabeatsu_pkg::*;

  logic       CLK = 1'b0;
  logic       RST, EN, CLR;
  logic [1:0] MODE;

  logic [9:0]  count_a, count_b;
  logic [11:0] bcd_a, bcd_b;
  logic        div_a, dig_a, aho_a, wrap_a;
  logic        div_b, dig_b, aho_b, wrap_b;

  nabeatsu_counter dut_a (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .MODE(MODE),
    .COUNT(count_a), .BCD(bcd_a), .DIV_HIT(div_a), .DIGIT_HIT(dig_a),
    .AHO(aho_a), .WRAP(wrap_a)
  );

  nabeatsu_counter #(.NUM_DIGITS(3), .MAX_COUNT(999), .DIVISOR(7), .MATCH_DIGIT(0)) dut_b (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .MODE(MODE),
    .COUNT(count_b), .BCD(bcd_b), .DIV_HIT(div_b), .DIGIT_HIT(dig_b),
    .AHO(aho_b), .WRAP(wrap_b)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned cnt;
    logic        wrap;
    logic [1:0]  mode;
  } exp_t;

  exp_t        sb[$];
  int unsigned m_cnt;
  logic        m_wrap;
  int          checks   = 0;
  int          failures = 0;

  function automatic bit f_div(input int unsigned c, input int unsigned d);
    return (c != 0) && (c % d == 0);
  endfunction

  function automatic bit f_dig(input int unsigned c, input int unsigned m);
    int unsigned v;
    v = c;
    while (v > 0) begin
      if (v % 10 == m) return 1'b1;
      v = v / 10;
    end
    return 1'b0;
  endfunction

  function automatic int unsigned f_bcd(input int unsigned c);
    return ((c / 100) % 10) * 256 + ((c / 10) % 10) * 16 + (c % 10);
  endfunction

  function automatic bit f_aho(input int unsigned c, input logic [1:0] md,
                               input int unsigned d, input int unsigned m);
    bit dv, dg;
    dv = f_div(c, d);
    dg = f_dig(c, m);
    if (c == 0) return 1'b0;
    case (md)
      2'b00:   return dv | dg;
      2'b01:   return dv;
      2'b10:   return dg;
      default: return dv & dg;
    endcase
  endfunction

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    chk("a_count", count_a, e.cnt);
    chk("a_bcd", bcd_a, f_bcd(e.cnt));
    chk("a_div", div_a, f_div(e.cnt, 3));
    chk("a_dig", dig_a, f_dig(e.cnt, 3));
    chk("a_aho", aho_a, f_aho(e.cnt, e.mode, 3, 3));
    chk("a_wrap", wrap_a, e.wrap);
    chk("b_count", count_b, e.cnt);
    chk("b_div", div_b, f_div(e.cnt, 7));
    chk("b_dig", dig_b, f_dig(e.cnt, 0));
    chk("b_aho", aho_b, f_aho(e.cnt, e.mode, 7, 0));
    chk("b_wrap", wrap_b, e.wrap);
    // Invariants
    chk("a_bcd_decode", bcd_to_bin({8'h00, bcd_a}, 3), count_a);
    chk("a_rem", dut_a.rem_q, count_a % 3);
    chk("b_rem", dut_b.rem_q, count_b % 7);
    chk("a_le_max", count_a <= 999, 1);
    // Spot values called out by the test plan
    if (e.cnt == 6 && e.mode == MODE_OR) chk("six_dig_low", dig_a, 0);
    if (e.cnt == 12) chk("bcd_twelve", bcd_a, 12'h012);
    if (e.cnt == 7) begin
      chk("b7_div", div_b, 1);
      chk("b7_dig", dig_b, 0);
    end
    if (e.cnt == 10) chk("b10_dig", dig_b, 1);
    if (e.cnt == 14) chk("b14_div", div_b, 1);
    if (e.mode == MODE_DIG && (e.cnt == 29 || e.cnt == 30 || e.cnt == 31 || e.cnt == 33))
      chk("dig_mode_aho", aho_a, (e.cnt != 29) ? 1 : 0);
    if (e.mode == MODE_AND && (e.cnt == 29 || e.cnt == 30 || e.cnt == 31 || e.cnt == 33))
      chk("and_mode_aho", aho_a, (e.cnt == 30 || e.cnt == 33) ? 1 : 0);
  endtask

  task automatic cyc(input logic en, input logic clr, input logic rst);
    exp_t e;
    EN  = en;
    CLR = clr;
    RST = rst;
    if (rst || clr) begin
      m_cnt  = 0;
      m_wrap = 1'b0;
    end else if (en) begin
      m_wrap = (m_cnt == 999);
      m_cnt  = (m_cnt == 999) ? 1 : m_cnt + 1;
    end else begin
      m_wrap = 1'b0;
    end
    sb.push_back('{cnt: m_cnt, wrap: m_wrap, mode: MODE});
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 0, 1);
    end else begin
      e = sb.pop_front();
      check_outputs(e);
    end
  endtask

  initial begin
    RST   = 1'b1;
    EN    = 1'b0;
    CLR   = 1'b0;
    MODE  = MODE_OR;
    m_cnt = 0;
    m_wrap = 1'b0;

    cyc(1'b0, 1'b0, 1'b1);
    chk("rst_count", count_a, 0);
    chk("rst_aho", aho_a, 0);

    // Count 1..12 in OR mode, then on to 33 in DIGIT mode
    repeat (12) cyc(1'b1, 1'b0, 1'b0);
    chk("count_after_12", count_a, 12);
    MODE = MODE_DIG;
    repeat (21) cyc(1'b1, 1'b0, 1'b0);
    chk("count_after_33", count_a, 33);

    // Clear and replay in AND mode
    cyc(1'b0, 1'b1, 1'b0);
    chk("clr_b_aho", aho_b, 0);
    chk("clr_b_dig", dig_b, 0);
    MODE = MODE_AND;
    repeat (33) cyc(1'b1, 1'b0, 1'b0);

    // Random enable up to 57, clear, then CLR+EN collision
    cyc(1'b0, 1'b1, 1'b0);
    MODE = MODE_OR;
    for (int i = 0; i < 600 && count_a != 57; i++) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    chk("reach57", count_a, 57);
    cyc(1'b0, 1'b1, 1'b0);
    chk("clr_at57", count_a, 0);
    for (int i = 0; i < 20; i++) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("collision", count_a, 0);

    // Run to the wrap
    MODE = MODE_DIV;
    for (int i = 0; i < 1100 && count_a != 999; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("reach999", count_a, 999);
    cyc(1'b1, 1'b0, 1'b0);
    chk("wrap_count", count_a, 1);
    chk("wrap_pulse", wrap_a, 1);
    chk("wrap_bcd", bcd_a, 12'h001);
    chk("wrap_rem", dut_a.rem_q, 1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("wrap_one_cycle", wrap_a, 0);

    // Reset at 999 with EN held
    for (int i = 0; i < 1100 && count_a != 999; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("reach999_again", count_a, 999);
    cyc(1'b1, 1'b0, 1'b1);
    chk("rst999_count", count_a, 0);
    chk("rst999_bcd", bcd_a, 0);
    chk("rst999_wrap", wrap_a, 0);
    chk("rst999_aho", aho_a, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rst999_wrap_after", wrap_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
